combo_lock_ctrl: RTL

Parametrised keypad combination-lock controller for the board-level lock design. It accumulates per-digit button weights into NDIG hex digits and compares them against a parameter code. It enforces a push limit and an entry-time window, and drives a multiplexed 7-segment status display plus blinking LEDs. All timing runs from an external 1-cycle tick strobe (nominal 500 Hz), so the block is frequency-independent.

---
 rtl/combo_lock_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: keypad combination-lock controller.
// Button edges accumulate per-digit weights into NDIG hex digits and are compared
// against CODE. A push limit and an entry window force a timed pause. A multiplexed
// 7-segment display shows the status and the LEDs blink while unlocked.
// All state advances only on the one-cycle 'tick' strobe; 'state' exposes the FSM.
// Optional feature macro: COMBO_LOCK_ESCALATE_EN (pause length doubles per
// consecutive failure, cleared by a successful unlock).
module combo_lock_ctrl #(
  parameter int                NDIG        = 4,
  parameter logic [4*NDIG-1:0] CODE        = 16'h3889,
  parameter int                MAX_PUSH    = 20,
  parameter int                ENTRY_TICKS = 5000,
  parameter int                PAUSE_TICKS = 2500,
  parameter int                BLINK_TICKS = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic [NDIG-1:0] sel,
  input  logic [3:0]      btn,
  input  logic            relock,
  output logic [NDIG-1:0] anodes,
  output logic [6:0]      cathodes,
  output logic [7:0]      leds,
  output logic [1:0]      state
);

  localparam int          SW           = $clog2(NDIG);
  localparam logic [15:0] LP_MAX_PUSH  = 16'(MAX_PUSH);
  localparam logic [31:0] LP_ENTRY     = 32'(ENTRY_TICKS);
  localparam logic [31:0] LP_PAUSE_LEN = 32'(PAUSE_TICKS + 1);
  localparam logic [15:0] LP_BLINK     = 16'(BLINK_TICKS);

  // Segment glyphs, bit order g..a, active-low
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_P     = 7'b0001100;

  // Per-state display words, element p is scan position p
  localparam logic [3:0][6:0] PAT_LOCKED   = {SEG_L, SEG_O, SEG_C, SEG_BLANK};
  localparam logic [3:0][6:0] PAT_UNLOCKED = {SEG_U, SEG_N, SEG_L, SEG_C};
  localparam logic [3:0][6:0] PAT_PAUSED   = {SEG_P, SEG_A, SEG_U, SEG_S};

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'b00,
    ST_UNLOCKED = 2'b01,
    ST_PAUSED   = 2'b10
  } state_t;

  state_t                r_state, w_state_next;
  logic [3:0]            r_btn_q;
  logic [NDIG-1:0][3:0]  r_digits, w_digits_next;
  logic [15:0]           r_push_cnt, w_push_next;
  logic [31:0]           r_entry_tmr, w_entry_next;
  logic                  r_armed, w_armed_next;
  logic [31:0]           r_pause_tmr, w_pause_next;
  logic [31:0]           w_pause_len;
  logic [SW-1:0]         r_scan, w_scan_next;
  logic [NDIG-1:0]       r_anodes, w_anodes_next;
  logic [6:0]            r_cathodes, w_cathodes_next;
  logic [7:0]            r_leds, w_leds_next;
  logic [15:0]           r_blink, w_blink_next;
  logic [3:0]            w_edges;
  logic [2:0]            w_edge_cnt;
  logic                  w_sel_onehot;
  logic                  w_counted;
  logic [3:0][6:0]       w_pat;
  logic [6:0]            w_seg;

  assign w_edges      = btn & ~r_btn_q;
  assign w_edge_cnt   = {2'b00, w_edges[0]} + {2'b00, w_edges[1]}
                      + {2'b00, w_edges[2]} + {2'b00, w_edges[3]};
  assign w_sel_onehot = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  assign w_counted    = w_sel_onehot && (w_edges != 4'd0);

`ifdef COMBO_LOCK_ESCALATE_EN
  logic [1:0] r_fail_cnt, w_fail_next;

  // The fail counter is at least 1 while paused; the first pause uses the base length
  assign w_pause_len = LP_PAUSE_LEN << (r_fail_cnt - 2'd1);

  // Count LOCKED->PAUSED transitions (saturating), clear on entering UNLOCKED
  always_comb begin
    w_fail_next = r_fail_cnt;
    if (tick && (r_state == ST_LOCKED) && (w_state_next == ST_PAUSED) && (r_fail_cnt != 2'd3))
      w_fail_next = r_fail_cnt + 2'd1;
    else if (tick && (r_state != ST_UNLOCKED) && (w_state_next == ST_UNLOCKED))
      w_fail_next = 2'd0;
  end

  // Failure counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fail_cnt <= 2'd0;
    else        r_fail_cnt <= w_fail_next;
  end
`else
  assign w_pause_len = LP_PAUSE_LEN;
`endif

  // Next state and code-entry datapath; nothing moves without tick
  always_comb begin
    w_state_next  = r_state;
    w_digits_next = r_digits;
    w_push_next   = r_push_cnt;
    w_entry_next  = r_entry_tmr;
    w_armed_next  = r_armed;
    w_pause_next  = r_pause_tmr;
    if (tick) begin
      case (r_state)
        ST_LOCKED: begin
          if (w_counted) begin
            for (int i = 0; i < NDIG; i++)
              if (sel[i]) w_digits_next[i] = r_digits[i] + w_edges;
            w_push_next  = r_push_cnt + {13'd0, w_edge_cnt};
            w_armed_next = 1'b1;
          end
          // The timer starts counting on the tick after the arming push
          if (r_armed) w_entry_next = r_entry_tmr + 32'd1;
          if (w_push_next > LP_MAX_PUSH)     w_state_next = ST_PAUSED;
          else if (w_entry_next > LP_ENTRY)  w_state_next = ST_PAUSED;
          else if (w_digits_next == CODE)    w_state_next = ST_UNLOCKED;
          if (w_state_next != ST_LOCKED) begin
            w_digits_next = '0;
            w_push_next   = 16'd0;
            w_entry_next  = 32'd0;
            w_armed_next  = 1'b0;
          end
        end
        ST_UNLOCKED: begin
          if (relock) w_state_next = ST_LOCKED;
        end
        ST_PAUSED: begin
          w_pause_next = r_pause_tmr + 32'd1;
          if (w_pause_next == w_pause_len) begin
            w_state_next = ST_LOCKED;
            w_pause_next = 32'd0;
          end
        end
        default: w_state_next = ST_LOCKED;
      endcase
    end
  end

  // Display scan and LED blink, both following the post-transition state
  always_comb begin
    w_scan_next     = r_scan;
    w_anodes_next   = r_anodes;
    w_cathodes_next = r_cathodes;
    w_leds_next     = r_leds;
    w_blink_next    = r_blink;
    w_seg           = SEG_BLANK;
    case (w_state_next)
      ST_UNLOCKED: w_pat = PAT_UNLOCKED;
      ST_PAUSED:   w_pat = PAT_PAUSED;
      default:     w_pat = PAT_LOCKED;
    endcase
    for (int p = 0; p < 4; p++)
      if (r_scan == SW'(p)) w_seg = w_pat[p];
    if (tick) begin
      w_scan_next     = (r_scan == SW'(NDIG - 1)) ? '0 : r_scan + 1'b1;
      w_cathodes_next = w_seg;
      w_anodes_next   = (w_seg == SEG_BLANK) ? '1 : ~(NDIG'(1) << r_scan);
      if (w_state_next == ST_UNLOCKED) begin
        if (r_state != ST_UNLOCKED) begin
          w_leds_next  = 8'hFF;
          w_blink_next = 16'd0;
        end else begin
          w_blink_next = r_blink + 16'd1;
          if (w_blink_next == LP_BLINK) begin
            w_leds_next  = ~r_leds;
            w_blink_next = 16'd0;
          end
        end
      end else begin
        w_leds_next  = 8'h00;
        w_blink_next = 16'd0;
      end
    end
  end

  // State register and all datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LOCKED;
      r_btn_q     <= 4'd0;
      r_digits    <= '0;
      r_push_cnt  <= 16'd0;
      r_entry_tmr <= 32'd0;
      r_armed     <= 1'b0;
      r_pause_tmr <= 32'd0;
      r_scan      <= '0;
      r_anodes    <= '1;
      r_cathodes  <= SEG_BLANK;
      r_leds      <= 8'h00;
      r_blink     <= 16'd0;
    end else begin
      r_state     <= w_state_next;
      if (tick) r_btn_q <= btn;
      r_digits    <= w_digits_next;
      r_push_cnt  <= w_push_next;
      r_entry_tmr <= w_entry_next;
      r_armed     <= w_armed_next;
      r_pause_tmr <= w_pause_next;
      r_scan      <= w_scan_next;
      r_anodes    <= w_anodes_next;
      r_cathodes  <= w_cathodes_next;
      r_leds      <= w_leds_next;
      r_blink     <= w_blink_next;
    end
  end

  assign state    = r_state;
  assign anodes   = r_anodes;
  assign cathodes = r_cathodes;
  assign leds     = r_leds;

endmodule
